// File: rtl/text_char_fetch.sv
// Text character fetcher: reads NUM_WORDS 32-bit words from an on-chip memory slave and
// streams out their bytes as characters (7-bit glyph code + inverse flag), little-endian,
// with a valid/ready handshake. The char_* and mem_* outputs are decoded straight from
// registered state, so they change only on clock edges or on asynchronous reset.
module text_char_fetch #(
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [6:0]        char_code,
  output logic              char_invert,
  output logic [3:0]        char_index,
  output logic              char_last
);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StEmit} state_e;

  localparam logic [1:0] LastWord = 2'(NUM_WORDS - 1);

  state_e      state_q;
  logic [1:0]  word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;
  logic        done_q;

  logic       emit;
  logic       last_byte;
  logic       is_last;
  logic [7:0] cur_byte;

  assign emit      = (state_q == StEmit);
  assign last_byte = (byte_cnt_q == 2'd3);
  assign is_last   = emit && last_byte && (word_cnt_q == LastWord);
  // Byte 0 sits in bits 7:0 and is emitted first.
  assign cur_byte  = word_q[{byte_cnt_q, 3'b000} +: 8];

  // Frame sequencing: abort beats everything except the idle start; done is a 1-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      word_cnt_q <= 2'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q    <= StIdle;
        word_cnt_q <= 2'd0;
        byte_cnt_q <= 2'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q    <= StRead;
              word_cnt_q <= 2'd0;
              byte_cnt_q <= 2'd0;
            end
          end
          StRead: state_q <= StWait;
          StWait: begin
            // Read data is valid one cycle after the strobe, i.e. at the end of this state.
            word_q     <= mem_readdata;
            byte_cnt_q <= 2'd0;
            state_q    <= StEmit;
          end
          StEmit: begin
            if (char_ready) begin
              if (!last_byte) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end else if (word_cnt_q == LastWord) begin
                state_q    <= StIdle;
                done_q     <= 1'b1;
                word_cnt_q <= 2'd0;
                byte_cnt_q <= 2'd0;
              end else begin
                word_cnt_q <= word_cnt_q + 2'd1;
                state_q    <= StRead;
              end
            end
          end
        endcase
      end
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign mem_address    = ADDR_W'(word_cnt_q);
  assign mem_chipselect = (state_q == StRead);
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  assign char_valid  = emit;
  assign char_code   = cur_byte[6:0];
  assign char_invert = cur_byte[7];
  assign char_index  = {word_cnt_q, byte_cnt_q};
  assign char_last   = is_last;

endmodule

// File: tb/tb_text_char_fetch.sv
// Bench for text_char_fetch: a 4-word instance and a 1-word instance against a small
// synchronous memory model; expected characters come from a hand-filled table.
module tb_text_char_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        start_1 = 1'b0;
  logic        abort = 1'b0;
  logic        char_ready = 1'b1;

  logic        busy, done, mem_chipselect, mem_write, mem_clken;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        char_valid, char_invert, char_last;
  logic [6:0]  char_code;
  logic [3:0]  char_index;

  logic        busy_1, done_1, mem_chipselect_1, mem_write_1, mem_clken_1;
  logic [1:0]  mem_address_1;
  logic [3:0]  mem_byteenable_1;
  logic [31:0] mem_readdata_1;
  logic        char_valid_1, char_invert_1, char_last_1;
  logic [6:0]  char_code_1;
  logic [3:0]  char_index_1;

  logic [31:0] mem [4];
  int          n_reads = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    logic [6:0] code;
    logic       invert;
    logic [3:0] index;
    logic       last;
    int         gap;
  } exp_t;
  exp_t exp_tab[16];

  always #5 clk = ~clk;

  text_char_fetch #(.NUM_WORDS(4), .ADDR_W(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
    .char_invert(char_invert), .char_index(char_index), .char_last(char_last)
  );

  text_char_fetch #(.NUM_WORDS(1), .ADDR_W(2)) u_dut_1 (
    .clk(clk), .reset_n(reset_n), .start(start_1), .abort(1'b0), .busy(busy_1),
    .done(done_1), .mem_address(mem_address_1), .mem_chipselect(mem_chipselect_1),
    .mem_write(mem_write_1), .mem_byteenable(mem_byteenable_1), .mem_clken(mem_clken_1),
    .mem_readdata(mem_readdata_1), .char_valid(char_valid_1), .char_ready(char_ready),
    .char_code(char_code_1), .char_invert(char_invert_1), .char_index(char_index_1),
    .char_last(char_last_1)
  );

  // Memory model: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_readdata <= mem[mem_address];
      n_reads <= n_reads + 1;
    end
    if (mem_chipselect_1) mem_readdata_1 <= mem[mem_address_1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int gap);
    gap = 0;
    while (!char_valid && gap < 10) begin
      step();
      gap++;
    end
  endtask

  task automatic check_char(input int i);
    check($sformatf("valid[%0d]", i), 32'(char_valid), 32'd1);
    check($sformatf("code[%0d]", i), 32'(char_code), 32'(exp_tab[i].code));
    check($sformatf("invert[%0d]", i), 32'(char_invert), 32'(exp_tab[i].invert));
    check($sformatf("index[%0d]", i), 32'(char_index), 32'(exp_tab[i].index));
    check($sformatf("last[%0d]", i), 32'(char_last), 32'(exp_tab[i].last));
    check($sformatf("no_read_in_emit[%0d]", i), 32'(mem_chipselect), 32'd0);
  endtask

  // Full frame with optional 5-cycle stall at stall_idx and a stray start at start_idx.
  task automatic run_frame(input int stall_idx, input int start_idx);
    int gap;
    int reads0;
    int reads_frame;
    reads_frame = n_reads;
    start = 1'b1;
    step();
    start = 1'b0;
    check("read_cycle_busy", 32'(busy), 32'd1);
    check("read_cycle_strobe", 32'(mem_chipselect), 32'd1);
    check("read_cycle_addr", 32'(mem_address), 32'd0);
    for (int i = 0; i < 16; i++) begin
      wait_valid(gap);
      check($sformatf("gap[%0d]", i), 32'(gap), 32'(exp_tab[i].gap));
      check_char(i);
      if (i == stall_idx) begin
        char_ready = 1'b0;
        reads0 = n_reads;
        for (int k = 0; k < 5; k++) begin
          step();
          check("stall_valid", 32'(char_valid), 32'd1);
          check("stall_code", 32'(char_code), 32'h43);
          check("stall_index", 32'(char_index), 32'd2);
        end
        check("stall_no_read", 32'(n_reads), 32'(reads0));
        char_ready = 1'b1;
      end
      if (i == start_idx) start = 1'b1;
      step();
      start = 1'b0;
    end
    check("frame_done", 32'(done), 32'd1);
    check("frame_idle", 32'(busy), 32'd0);
    check("frame_valid_off", 32'(char_valid), 32'd0);
    check("frame_reads", 32'(n_reads - reads_frame), 32'd4);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int gap;
    mem[0] = 32'h44434241;
    mem[1] = 32'h48474645;
    mem[2] = 32'h4C4B4A49;
    mem[3] = 32'hD0CFCECD;
    for (int i = 0; i < 16; i++) begin
      exp_tab[i].code   = 7'(8'h41 + i);
      exp_tab[i].invert = (i >= 12);
      exp_tab[i].index  = 4'(i);
      exp_tab[i].last   = (i == 15);
      exp_tab[i].gap    = (i % 4 == 0) ? 2 : 0;
    end

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_last", 32'(char_last), 32'd0);
    check("rst_code", 32'(char_code), 32'd0);
    check("rst_invert", 32'(char_invert), 32'd0);
    check("rst_index", 32'(char_index), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("const_write", 32'(mem_write), 32'd0);
    check("const_be", 32'(mem_byteenable), 32'hF);
    check("const_clken", 32'(mem_clken), 32'd1);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("idle_after_reset", 32'(busy), 32'd0);

    // Plain frame, then stall on index 2, then a stray start on index 9
    run_frame(-1, -1);
    run_frame(2, -1);
    run_frame(-1, 9);

    // Abort on index 6, then a clean restart from index 0
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      wait_valid(gap);
      check_char(i);
      if (i < 6) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_valid", 32'(char_valid), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    step();
    check("abort_no_done_late", 32'(done), 32'd0);
    run_frame(-1, -1);

    // Abort together with the last handshake: no done
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 15; i++) begin
      wait_valid(gap);
      check_char(i);
      if (i < 15) step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_last_no_done", 32'(done), 32'd0);
    check("abort_last_idle", 32'(busy), 32'd0);
    step();
    check("abort_last_no_done_late", 32'(done), 32'd0);

    // Abort alone in idle does nothing; start beats abort in idle
    abort = 1'b1;
    step();
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_done", 32'(done), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_wins_busy", 32'(busy), 32'd1);
    check("start_wins_strobe", 32'(mem_chipselect), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_read", 32'(busy), 32'd0);

    // Reset pulse during WAIT of word 2
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      wait_valid(gap);
      check_char(i);
      step();
    end
    check("w2_read_addr", 32'(mem_address), 32'd2);
    check("w2_read_strobe", 32'(mem_chipselect), 32'd1);
    step();
    check("w2_wait_strobe", 32'(mem_chipselect), 32'd0);
    check("w2_wait_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(char_valid), 32'd0);
    check("midrst_code", 32'(char_code), 32'd0);
    check("midrst_index", 32'(char_index), 32'd0);
    check("midrst_addr", 32'(mem_address), 32'd0);
    check("midrst_cs", 32'(mem_chipselect), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    step();
    check("midrst_stays_idle", 32'(busy), 32'd0);
    check("midrst_no_valid", 32'(char_valid), 32'd0);
    run_frame(-1, -1);

    // Single-word instance
    start_1 = 1'b1;
    step();
    start_1 = 1'b0;
    check("nw1_strobe", 32'(mem_chipselect_1), 32'd1);
    check("nw1_addr", 32'(mem_address_1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      gap = 0;
      while (!char_valid_1 && gap < 10) begin
        step();
        gap++;
      end
      check($sformatf("nw1_valid[%0d]", i), 32'(char_valid_1), 32'd1);
      check($sformatf("nw1_code[%0d]", i), 32'(char_code_1), 32'(8'h41 + i));
      check($sformatf("nw1_index[%0d]", i), 32'(char_index_1), 32'(i));
      check($sformatf("nw1_last[%0d]", i), 32'(char_last_1), 32'(i == 3));
      check($sformatf("nw1_addr[%0d]", i), 32'(mem_address_1), 32'd0);
      step();
    end
    check("nw1_done", 32'(done_1), 32'd1);
    check("nw1_idle", 32'(busy_1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
